// File: rtl/led_frame_loader.sv
// led_frame_loader
//
// Double-buffered grayscale frame store sitting in front of the LED panel
// scan/serializer. A byte stream is hunted for a frame-start marker, then
// 3456 pixel bytes are gamma-expanded to 12 bits and written into the back
// bank. Once the last word is committed the block waits for the scan
// driver's frame_sync pulse and swaps banks, so the read port always
// presents one complete, stable frame.
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       synchronous active-low reset
//   in_data       pixel or marker byte
//   in_valid      in_data valid
//   in_ready      byte accepted when in_valid & in_ready
//   frame_sync    one-cycle pulse from the scan driver (row wrap 7->0)
//   rd_en         read request from the scan driver
//   rd_addr       word index into the front bank, 0..3455
//   rd_data       12-bit grayscale word, valid the cycle after rd_en
//   front_bank    bank currently presented on the read port
//   swap_pending  back bank holds a complete frame awaiting frame_sync
//   sync_err      one-cycle pulse when a non-marker byte is dropped in SYNC
//   frame_count   number of frames swapped in, wraps 255->0

module led_frame_loader #(
    parameter bit         GAMMA     = 1'b1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        frame_sync,
    input  logic        rd_en,
    input  logic [11:0] rd_addr,
    output logic [11:0] rd_data,
    output logic        front_bank,
    output logic        swap_pending,
    output logic        sync_err,
    output logic [7:0]  frame_count
);

    localparam logic [11:0] LAST_IDX   = 12'd3455;
    localparam logic [12:0] BANK_WORDS = 13'd3456;

    typedef enum logic [1:0] {ST_SYNC, ST_LOAD, ST_HOLD} state_t;

    state_t      state_q, state_d;
    logic [11:0] wcnt_q, wcnt_d;
    logic        in_ready_q, in_ready_d;
    logic        front_bank_q, front_bank_d;
    logic        swap_pending_q, swap_pending_d;
    logic        sync_err_q, sync_err_d;
    logic [7:0]  frame_count_q, frame_count_d;

    // Stage 1: accepted pixel byte and its word index.
    logic        p1_valid_q, p1_valid_d;
    logic        p1_last_q, p1_last_d;
    logic [7:0]  p1_byte_q, p1_byte_d;
    logic [11:0] p1_addr_q, p1_addr_d;

    // Stage 2: gamma-expanded word ready to be written.
    logic        p2_valid_q, p2_valid_d;
    logic        p2_last_q, p2_last_d;
    logic [11:0] p2_word_q, p2_word_d;
    logic [11:0] p2_addr_q, p2_addr_d;

    logic [11:0] rd_data_q;
    logic [15:0] square;
    logic        accept;
    logic [12:0] wr_index;
    logic [12:0] rd_index;

    logic [11:0] mem [0:6911];

    assign accept = in_valid & in_ready_q;

    // Next-state logic for the control FSM and the two pipeline stages.
    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        front_bank_d   = front_bank_q;
        swap_pending_d = swap_pending_q;
        frame_count_d  = frame_count_q;
        sync_err_d     = 1'b0;
        p1_valid_d     = 1'b0;
        p1_last_d      = 1'b0;
        p1_byte_d      = p1_byte_q;
        p1_addr_d      = p1_addr_q;

        case (state_q)
            ST_SYNC: begin
                if (accept) begin
                    if (in_data == SYNC_BYTE) begin
                        state_d = ST_LOAD;
                        wcnt_d  = 12'd0;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // No marker detection here: every byte is pixel data.
                if (accept) begin
                    p1_valid_d = 1'b1;
                    p1_byte_d  = in_data;
                    p1_addr_d  = wcnt_q;
                    if (wcnt_q == LAST_IDX) begin
                        p1_last_d = 1'b1;
                        wcnt_d    = 12'd0;
                        state_d   = ST_HOLD;
                    end else begin
                        wcnt_d = wcnt_q + 12'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_sync && swap_pending_q) begin
                    front_bank_d   = ~front_bank_q;
                    frame_count_d  = frame_count_q + 8'd1;
                    swap_pending_d = 1'b0;
                    state_d        = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // The last word is written on this edge, so the frame is complete
        // from the next cycle on; an earlier frame_sync is ignored above.
        if (p2_valid_q && p2_last_q) begin
            swap_pending_d = 1'b1;
        end

        in_ready_d = (state_d != ST_HOLD);

        square     = {8'd0, p1_byte_q} * {8'd0, p1_byte_q};
        p2_valid_d = p1_valid_q;
        p2_last_d  = p1_last_q;
        p2_addr_d  = p1_addr_q;
        if (GAMMA) begin
            p2_word_d = square[15:4];
        end else begin
            p2_word_d = {p1_byte_q, p1_byte_q[7:4]};
        end
    end

    // Writes always land in the back bank; reads always come from the front.
    assign wr_index = {1'b0, p2_addr_q} + (front_bank_q ? 13'd0 : BANK_WORDS);
    assign rd_index = {1'b0, rd_addr} + (front_bank_q ? BANK_WORDS : 13'd0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_SYNC;
            wcnt_q         <= 12'd0;
            in_ready_q     <= 1'b0;
            front_bank_q   <= 1'b0;
            swap_pending_q <= 1'b0;
            sync_err_q     <= 1'b0;
            frame_count_q  <= 8'd0;
            p1_valid_q     <= 1'b0;
            p1_last_q      <= 1'b0;
            p1_byte_q      <= 8'd0;
            p1_addr_q      <= 12'd0;
            p2_valid_q     <= 1'b0;
            p2_last_q      <= 1'b0;
            p2_word_q      <= 12'd0;
            p2_addr_q      <= 12'd0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            in_ready_q     <= in_ready_d;
            front_bank_q   <= front_bank_d;
            swap_pending_q <= swap_pending_d;
            sync_err_q     <= sync_err_d;
            frame_count_q  <= frame_count_d;
            p1_valid_q     <= p1_valid_d;
            p1_last_q      <= p1_last_d;
            p1_byte_q      <= p1_byte_d;
            p1_addr_q      <= p1_addr_d;
            p2_valid_q     <= p2_valid_d;
            p2_last_q      <= p2_last_d;
            p2_word_q      <= p2_word_d;
            p2_addr_q      <= p2_addr_d;
        end
    end

    // Frame memory is deliberately not reset. Pipeline valids are cleared by
    // reset, which squashes any write still in flight.
    always_ff @(posedge clock) begin
        if (p2_valid_q) begin
            mem[wr_index] <= p2_word_q;
        end
    end

    // Registered read port; out-of-range addresses return zero and the
    // output holds while rd_en is low.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data_q <= 12'd0;
        end else if (rd_en) begin
            if (rd_addr <= LAST_IDX) begin
                rd_data_q <= mem[rd_index];
            end else begin
                rd_data_q <= 12'd0;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign rd_data      = rd_data_q;
    assign front_bank   = front_bank_q;
    assign swap_pending = swap_pending_q;
    assign sync_err     = sync_err_q;
    assign frame_count  = frame_count_q;

endmodule
